// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator back end: readout FSM states,
// count width and out_sel byte-identity encodings.
package mac_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] SEL_LO  = 2'd0;
    localparam logic [1:0] SEL_HI  = 2'd1;
    localparam logic [1:0] SEL_CNT = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_LO  = 2'd1,
        RD_HI  = 2'd2,
        RD_CNT = 2'd3
    } state_e;

endpackage

// File: rtl/mac_if.sv
// Product-input handshake and serialised readout bus of mac_accumulator.
// master = product source / readout consumer, slave = the accumulator.
interface mac_if;

    logic [7:0] prod_i;
    logic       prod_valid_i;
    logic       prod_ready_o;
    logic       acc_clear_i;
    logic       rd_req_i;
    logic [7:0] out_byte_o;
    logic [1:0] out_sel_o;
    logic       out_valid_o;
    logic       ovf_o;

    modport master (
        output prod_i, prod_valid_i, acc_clear_i, rd_req_i,
        input  prod_ready_o, out_byte_o, out_sel_o, out_valid_o, ovf_o
    );

    modport slave (
        input  prod_i, prod_valid_i, acc_clear_i, rd_req_i,
        output prod_ready_o, out_byte_o, out_sel_o, out_valid_o, ovf_o
    );

endinterface

// File: rtl/mac_readout_ser.sv
// Snapshot registers and the three-cycle RD_LO -> RD_HI -> RD_CNT sequencer.
// Outputs are decoded from registered state and snapshot only.
module mac_readout_ser
    import mac_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             snap_i,
    input  logic [ACC_W-1:0] acc_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [7:0]       out_byte_o,
    output logic [1:0]       out_sel_o,
    output logic             out_valid_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] snap_acc_q;
    logic [CNT_W-1:0] snap_cnt_q;
    logic             snap_en;
    logic [7:0]       hi_byte;

    // Requests outside IDLE are dropped; a held level restarts on return.
    assign snap_en = snap_i && (state_q == IDLE);
    assign hi_byte = 8'(snap_acc_q >> 8);
    assign busy_o  = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            // NOTE: the snapshot is reset too, so a readout straight after reset is defined.
            snap_acc_q <= '0;
            snap_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            if (snap_en) begin
                snap_acc_q <= acc_i;
                snap_cnt_q <= cnt_i;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first, so no branch leaves a signal unassigned (no latch).
        state_d     = state_q;
        out_byte_o  = 8'h00;
        out_sel_o   = SEL_LO;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap_en) state_d = RD_LO;
            end
            RD_LO: begin
                out_valid_o = 1'b1;
                out_byte_o  = snap_acc_q[7:0];
                out_sel_o   = SEL_LO;
                state_d     = RD_HI;
            end
            RD_HI: begin
                out_valid_o = 1'b1;
                out_byte_o  = hi_byte;
                out_sel_o   = SEL_HI;
                state_d     = RD_CNT;
            end
            RD_CNT: begin
                out_valid_o = 1'b1;
                out_byte_o  = snap_cnt_q;
                out_sel_o   = SEL_CNT;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/mac_accumulator.sv
// Multiply-accumulate back end: sums products, counts samples, flags overflow
// and serialises a snapshot. Define MAC_SATURATE_EN to clamp instead of wrap.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    mac_if.slave bus
);

    logic [ACC_W-1:0] acc_q, acc_d, acc_base;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             ovf_q, ovf_d, ovf_base;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             accept;
    logic             busy;

    assign accept           = bus.prod_valid_i && !busy;
    assign bus.prod_ready_o = !busy;
    assign bus.ovf_o        = ovf_q;

    // Clear is applied before the accept, so clear+accept yields acc = prod.
    always_comb begin
        acc_base = bus.acc_clear_i ? '0   : acc_q;
        cnt_base = bus.acc_clear_i ? '0   : cnt_q;
        ovf_base = bus.acc_clear_i ? 1'b0 : ovf_q;
        sum      = {1'b0, acc_base} + {{(ACC_W-7){1'b0}}, bus.prod_i};
        carry    = sum[ACC_W];
        acc_d    = acc_base;
        cnt_d    = cnt_base;
        ovf_d    = ovf_base;
        if (accept) begin
`ifdef MAC_SATURATE_EN
            acc_d = carry ? '1 : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            ovf_d = ovf_base | carry;
            cnt_d = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // The snapshot takes next-state values so same-cycle accept/clear are included.
    mac_readout_ser #(
        .ACC_W (ACC_W)
    ) u_readout_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .snap_i      (bus.rd_req_i),
        .acc_i       (acc_d),
        .cnt_i       (cnt_d),
        .out_byte_o  (bus.out_byte_o),
        .out_sel_o   (bus.out_sel_o),
        .out_valid_o (bus.out_valid_o),
        .busy_o      (busy)
    );

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed scenarios plus random
// traffic compared against an integer-arithmetic reference model.
module tb_mac_accumulator;
    import mac_pkg::*;

    localparam int ACC_W   = 16;
    localparam int ACC_MAX = (1 << ACC_W) - 1;
`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } out_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mac_if bus ();

    mac_accumulator #(
        .ACC_W (ACC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   m_acc;
    int   m_cnt;
    bit   m_ovf;
    out_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
        exp_q.delete();
    endtask

    // Expected bus view: idle when no readout bytes are pending.
    task automatic check_outputs();
        if (exp_q.size() == 0) begin
            check("idle_valid", bus.out_valid_o, 0);
            check("idle_byte", bus.out_byte_o, 0);
            check("idle_sel", bus.out_sel_o, 0);
            check("idle_ready", bus.prod_ready_o, 1);
        end else begin
            check("rd_valid", bus.out_valid_o, 1);
            check("rd_byte", bus.out_byte_o, exp_q[0].data);
            check("rd_sel", bus.out_sel_o, exp_q[0].sel);
            check("rd_ready", bus.prod_ready_o, 0);
        end
        check("ovf", bus.ovf_o, m_ovf);
    endtask

    // One clock: drive inputs, check current outputs, advance the model, tick.
    task automatic cycle(input bit v, input logic [7:0] p, input bit clr, input bit rd);
        bit idle;
        bus.prod_valid_i = v;
        bus.prod_i       = p;
        bus.acc_clear_i  = clr;
        bus.rd_req_i     = rd;
        check_outputs();
        idle = (exp_q.size() == 0);
        if (clr) begin
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end
        if (v && idle) begin
            m_acc += int'(p);
            if (m_acc > ACC_MAX) begin
                m_ovf = 1'b1;
                m_acc = SAT ? ACC_MAX : m_acc % (ACC_MAX + 1);
            end
            if (m_cnt < 255) m_cnt++;
        end
        if (!idle) begin
            void'(exp_q.pop_front());
        end else if (rd) begin
            exp_q.push_back('{sel: SEL_LO,  data: 8'(m_acc)});
            exp_q.push_back('{sel: SEL_HI,  data: 8'(m_acc >> 8)});
            exp_q.push_back('{sel: SEL_CNT, data: 8'(m_cnt)});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int low_cnt;
        bus.prod_i       = 8'h00;
        bus.prod_valid_i = 1'b0;
        bus.acc_clear_i  = 1'b0;
        bus.rd_req_i     = 1'b0;
        model_reset();

        // Reset state
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three accepts of 15*15, then readout
        repeat (3) cycle(1'b1, 8'hE1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t1_lo", bus.out_byte_o, 8'hA3);
        check("t1_lo_sel", bus.out_sel_o, 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t1_hi", bus.out_byte_o, 8'h02);
        check("t1_hi_sel", bus.out_sel_o, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t1_cnt", bus.out_byte_o, 8'h03);
        check("t1_cnt_sel", bus.out_sel_o, 2);
        check("t1_ovf", bus.ovf_o, 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Clear and accept in the same cycle
        cycle(1'b1, 8'h10, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_lo", bus.out_byte_o, 8'h10);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t2_hi", bus.out_byte_o, 8'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t2_cnt", bus.out_byte_o, 8'h01);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Overflow after the 292nd accept; count saturates
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (291) cycle(1'b1, 8'hE1, 1'b0, 1'b0);
        check("t3_ovf_291", bus.ovf_o, 0);
        cycle(1'b1, 8'hE1, 1'b0, 1'b0);
        check("t3_ovf_292", bus.ovf_o, 1);
        repeat (8) cycle(1'b1, 8'hE1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t3_lo", bus.out_byte_o, SAT ? 8'hFF : 8'hAC);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t3_hi", bus.out_byte_o, SAT ? 8'hFF : 8'h07);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t3_cnt", bus.out_byte_o, 8'hFF);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Valid held high through a readout: ready low for exactly 3 cycles
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, i == 2);
            if (!bus.prod_ready_o) low_cnt++;
        end
        check("t4_ready_low", low_cnt, 3);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Read request coincides with an accept; clear during RD_HI
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h80, 1'b0, 1'b0);
        cycle(1'b1, 8'h80, 1'b0, 1'b0);
        cycle(1'b1, 8'h05, 1'b0, 1'b1);
        check("t5_lo", bus.out_byte_o, 8'h05);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t5_hi", bus.out_byte_o, 8'h01);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("t5_cnt", bus.out_byte_o, 8'h03);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_cleared_lo", bus.out_byte_o, 8'h00);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in RD_HI
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", bus.out_valid_o, 0);
        check("t6_rst_ready", bus.prod_ready_o, 1);
        check("t6_rst_byte", bus.out_byte_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t6_lo", bus.out_byte_o, 8'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t6_hi", bus.out_byte_o, 8'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t6_cnt", bus.out_byte_o, 8'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic against the model
        repeat (500) begin
            cycle($urandom_range(0, 3) != 0,
                  8'($urandom_range(0, 15) * $urandom_range(0, 15)),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) == 0);
        end
        repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
